// File: rtl/nes_joypad_responder.sv
// Two-port NES controller responder: synchronized, debounced buttons latched into 4021-style serial shift registers.
// Optional turbo A/B modulation is enabled by defining NES_JOYPAD_TURBO_EN.
module nes_joypad_responder #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int TURBO_DIV       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [7:0]  buttons_p0,
    input  logic [7:0]  buttons_p1,
    input  logic [1:0]  turbo_a,
    input  logic [1:0]  turbo_b,
    input  logic        joypad_strobe,
    input  logic [1:0]  joypad_clock,
    output logic [1:0]  joypad_data,
    output logic [15:0] buttons_stable
);
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [15:0]            sync_meta;
    logic [15:0]            sync_q;
    logic [CNT_W-1:0]       db_cnt [16];
    logic [1:0]             prev_clk;
    logic [1:0][7:0]        sr;
    logic [1:0][7:0]        eff;

    // The synchronizer runs every clk so metastability settling never depends on ce.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {buttons_p1, buttons_p0};
            sync_q    <= sync_meta;
        end
    end

    // NOTE: the debounce counters are discrete flops, not a RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) db_cnt[i] <= '0;
            buttons_stable <= '0;
        end else if (ce) begin
            for (int i = 0; i < 16; i++) begin
                if (sync_q[i] == buttons_stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    buttons_stable[i] <= sync_q[i];
                    db_cnt[i]         <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef NES_JOYPAD_TURBO_EN
    localparam int                TDIV_W   = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [TDIV_W-1:0] TDIV_MAX = TDIV_W'(TURBO_DIV - 1);

    logic [3:0]        tsync_meta;
    logic [3:0]        tsync_q;
    logic              prev_strobe;
    logic [TDIV_W-1:0] turbo_cnt;
    logic              turbo_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tsync_meta <= '0;
            tsync_q    <= '0;
        end else begin
            tsync_meta <= {turbo_b, turbo_a};
            tsync_q    <= tsync_meta;
        end
    end

    // The phase advances once per TURBO_DIV completed polls (strobe falling edges).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_strobe <= 1'b0;
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (ce) begin
            prev_strobe <= joypad_strobe;
            if (prev_strobe && !joypad_strobe) begin
                if (turbo_cnt == TDIV_MAX) begin
                    turbo_cnt   <= '0;
                    turbo_phase <= ~turbo_phase;
                end else begin
                    turbo_cnt <= turbo_cnt + 1'b1;
                end
            end
        end
    end

    // NOTE: eff is fully assigned before the per-bit overrides, so no latch can be inferred.
    always_comb begin
        eff = buttons_stable;
        for (int p = 0; p < 2; p++) begin
            eff[p][0] = buttons_stable[p*8]     | (tsync_q[p]     & turbo_phase);
            eff[p][1] = buttons_stable[p*8 + 1] | (tsync_q[2 + p] & turbo_phase);
        end
    end
`else
    localparam int unused_turbo_div = TURBO_DIV;
    logic unused_turbo;
    assign unused_turbo = ^{turbo_a, turbo_b};

    always_comb begin
        eff = buttons_stable;
    end
`endif

    // Strobe reloads every ce cycle and wins over a coincident clock edge; shifting pulls in 1s from the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_clk    <= '0;
            sr          <= '0;
            joypad_data <= '0;
        end else if (ce) begin
            prev_clk <= joypad_clock;
            for (int p = 0; p < 2; p++) begin
                joypad_data[p] <= sr[p][0];
                if (joypad_strobe) begin
                    sr[p] <= eff[p];
                end else if (joypad_clock[p] && !prev_clk[p]) begin
                    sr[p] <= {1'b1, sr[p][7:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Self-checking bench for nes_joypad_responder: directed scenarios plus randomized traffic against a run-length/queue reference model.
module tb_nes_joypad_responder;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic [7:0]  buttons_p0 = '0;
    logic [7:0]  buttons_p1 = '0;
    logic [1:0]  turbo_a = '0;
    logic [1:0]  turbo_b = '0;
    logic        joypad_strobe = 1'b0;
    logic [1:0]  joypad_clock = '0;
    logic [1:0]  joypad_data;
    logic [15:0] buttons_stable;

    int checks = 0;
    int errors = 0;

    nes_joypad_responder #(.DEBOUNCE_CYCLES(D), .TURBO_DIV(2)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .buttons_p0(buttons_p0), .buttons_p1(buttons_p1),
        .turbo_a(turbo_a), .turbo_b(turbo_b),
        .joypad_strobe(joypad_strobe), .joypad_clock(joypad_clock),
        .joypad_data(joypad_data), .buttons_stable(buttons_stable)
    );

    initial forever #5 clk = ~clk;

    // Reference model: raw inputs seen two clocks late, a button is accepted after D equal ce samples,
    // a poll latches a byte and each read edge advances an index into it (past 7 reads give 1).
    logic [19:0]      raw_now;
    logic [19:0]      raw_d1, raw_d2;
    int               run_len [16];
    logic [15:0]      run_val;
    logic [15:0]      m_stable;
    int               falls;
    logic             m_prev_strobe;
    logic [1:0]       m_prev_clk;
    logic [1:0][7:0]  m_byte;
    int               m_reads [2];
    logic [1:0]       exp_data;
    logic [1:0][7:0]  m_eff;

    assign raw_now = {turbo_b, turbo_a, buttons_p1, buttons_p0};

`ifdef NES_JOYPAD_TURBO_EN
    localparam int TD = 2;
    always_comb begin
        m_eff = m_stable;
        for (int p = 0; p < 2; p++) begin
            m_eff[p][0] = m_stable[p*8]     | (raw_d2[16 + p] & (((falls / TD) % 2) == 1));
            m_eff[p][1] = m_stable[p*8 + 1] | (raw_d2[18 + p] & (((falls / TD) % 2) == 1));
        end
    end
`else
    logic unused_tb;
    assign unused_tb = ^raw_d2[19:16];
    always_comb begin
        m_eff = m_stable;
    end
`endif

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_d1 <= '0; raw_d2 <= '0;
            for (int i = 0; i < 16; i++) run_len[i] <= 0;
            run_val <= '0; m_stable <= '0; falls <= 0;
            m_prev_strobe <= 1'b0; m_prev_clk <= '0; m_byte <= '0;
            m_reads[0] <= 0; m_reads[1] <= 0; exp_data <= '0;
        end else begin
            raw_d1 <= raw_now;
            raw_d2 <= raw_d1;
            if (ce) begin
                for (int p = 0; p < 2; p++) begin
                    exp_data[p] <= (m_reads[p] < 8) ? m_byte[p][m_reads[p][2:0]] : 1'b1;
                    if (joypad_strobe) begin
                        m_byte[p]  <= m_eff[p];
                        m_reads[p] <= 0;
                    end else if (joypad_clock[p] && !m_prev_clk[p] && m_reads[p] < 8) begin
                        m_reads[p] <= m_reads[p] + 1;
                    end
                end
                for (int i = 0; i < 16; i++) begin
                    if (raw_d2[i] == run_val[i]) begin
                        run_len[i] <= run_len[i] + 1;
                        if (run_len[i] + 1 >= D && run_val[i] != m_stable[i]) m_stable[i] <= run_val[i];
                    end else begin
                        run_val[i] <= raw_d2[i];
                        run_len[i] <= 1;
                        if (D == 1 && raw_d2[i] != m_stable[i]) m_stable[i] <= raw_d2[i];
                    end
                end
                if (m_prev_strobe && !joypad_strobe) falls <= falls + 1;
                m_prev_strobe <= joypad_strobe;
                m_prev_clk    <= joypad_clock;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("data_vs_model", {30'd0, joypad_data}, {30'd0, exp_data});
            chk("stable_vs_model", {16'd0, buttons_stable}, {16'd0, m_stable});
        end
    endtask

    task automatic poll_start();
        joypad_strobe = 1'b1;
        step(2);
        joypad_strobe = 1'b0;
        step(2);
    endtask

    task automatic pulse(input int p);
        joypad_clock[p] = 1'b1;
        step(1);
        joypad_clock[p] = 1'b0;
        step(1);
    endtask

    initial begin
        logic [7:0] exp_seq;
        logic [5:0] turbo_seq;

        // Reset state
        step(3);
        chk("reset_data", {30'd0, joypad_data}, 32'd0);
        chk("reset_stable", {16'd0, buttons_stable}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(2);

        // Latch-and-read, including exact debounce latency
        buttons_p0 = 8'h09;
        step(5);
        chk("debounce_not_yet", {16'd0, buttons_stable}, 32'd0);
        step(1);
        chk("debounce_accept", {16'd0, buttons_stable}, 32'h0009);
        step(4);
        poll_start();
        exp_seq = 8'h09;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("read_p0_%0d", k), {31'd0, joypad_data[0]},
                {31'd0, (k < 8) ? exp_seq[k] : 1'b1});
            pulse(0);
        end

        // Debounce reject of a 2-cycle glitch on port 1 A
        buttons_p1[0] = 1'b1;
        step(2);
        buttons_p1[0] = 1'b0;
        step(8);
        chk("glitch_rejected", {31'd0, buttons_stable[8]}, 32'd0);
        poll_start();
        chk("glitch_p1_a", {31'd0, joypad_data[1]}, 32'd0);

        // Strobe priority over clock edges
        buttons_p0 = 8'h01;
        step(10);
        joypad_strobe = 1'b1;
        step(2);
        for (int k = 0; k < 3; k++) begin
            pulse(0);
            chk($sformatf("strobe_hold_%0d", k), {31'd0, joypad_data[0]}, 32'd1);
        end
        joypad_strobe = 1'b0;
        step(2);
        chk("strobe_first_read", {31'd0, joypad_data[0]}, 32'd1);

        // Port independence and ce=0 hold
        buttons_p0 = 8'h80;
        buttons_p1 = 8'h01;
        step(10);
        poll_start();
        for (int k = 0; k < 7; k++) pulse(0);
        chk("indep_p0_right", {31'd0, joypad_data[0]}, 32'd1);
        chk("indep_p1_a", {31'd0, joypad_data[1]}, 32'd1);
        ce = 1'b0;
        pulse(1);
        chk("ce_low_hold_p1", {31'd0, joypad_data[1]}, 32'd1);
        ce = 1'b1;
        step(1);
        pulse(1);
        chk("p1_b_after_ce", {31'd0, joypad_data[1]}, 32'd0);

        // Reset mid-poll
        buttons_p0 = 8'h05;
        step(10);
        poll_start();
        for (int k = 0; k < 3; k++) pulse(0);
        chk("midpoll_bit3", {31'd0, joypad_data[0]}, 32'd0);
        reset = 1'b0;
        #1;
        chk("midpoll_reset_data", {30'd0, joypad_data}, 32'd0);
        chk("midpoll_reset_stable", {16'd0, buttons_stable}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(10);
        poll_start();
        chk("after_reset_a", {31'd0, joypad_data[0]}, 32'd1);
        pulse(0);
        chk("after_reset_b", {31'd0, joypad_data[0]}, 32'd0);
        pulse(0);
        chk("after_reset_sel", {31'd0, joypad_data[0]}, 32'd1);

        // Randomized traffic, compared against the model on every clock
        for (int it = 0; it < 250; it++) begin
            int act;
            int idx;
            act = $urandom_range(0, 5);
            ce = ($urandom_range(0, 3) != 0);
            case (act)
                0: begin
                    buttons_p0 = 8'($urandom);
                    buttons_p1 = 8'($urandom);
                end
                1: begin
                    idx = $urandom_range(0, 7);
                    buttons_p0[idx] = ~buttons_p0[idx];
                    step($urandom_range(1, 3));
                    buttons_p0[idx] = ~buttons_p0[idx];
                end
                2: joypad_strobe = ~joypad_strobe;
                3: joypad_clock = 2'($urandom);
                4: begin
                    turbo_a = 2'($urandom);
                    turbo_b = 2'($urandom);
                end
                default: ;
            endcase
            step($urandom_range(1, 6));
        end
        ce = 1'b1;
        joypad_strobe = 1'b0;
        joypad_clock = '0;
        turbo_a = '0;
        turbo_b = '0;
        step(4);

`ifdef NES_JOYPAD_TURBO_EN
        // Turbo A on port 0 with no buttons pressed
        reset = 1'b0;
        buttons_p0 = '0;
        buttons_p1 = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        turbo_a = 2'b01;
        step(4);
        turbo_seq = 6'b001100;
        for (int k = 0; k < 6; k++) begin
            poll_start();
            chk($sformatf("turbo_poll_%0d", k), {31'd0, joypad_data[0]}, {31'd0, turbo_seq[k]});
        end
`else
        turbo_seq = '0;
        chk("turbo_ignored_a", {31'd0, joypad_data[0]}, {31'd0, turbo_seq[0]});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
